// File: rtl/stepper_step_sequencer.sv
// Stepper step sequencer: latches a move command, times steps with a rate counter, drives coil phases.
// Optional trapezoidal speed ramp is compiled in with `define STEPPER_RAMP_EN.
module stepper_step_sequencer #(
    parameter int DIV_W       = 26,
    parameter int STEP_W      = 16,
    parameter int MIN_DIV     = 15000000,
    parameter int START_DIV   = 60000000,
    parameter int ACCEL_DEC   = 5000000,
    parameter int HOLD_TORQUE = 0
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              dir,
    input  logic              half_step,
    input  logic [STEP_W-1:0] steps_target,
    output logic [3:0]        coil,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_count
);

    // state  | meaning
    // S_IDLE | no move; coils de-energised unless HOLD_TORQUE
    // S_RUN  | move in progress, rate counter timing steps
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [DIV_W-1:0]  MIN_P    = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0]  CNT_ONE  = DIV_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    if (MIN_DIV < 2 || START_DIV < MIN_DIV || ACCEL_DEC < 0) begin : g_param_check
        $error("stepper_step_sequencer: illegal rate parameters");
    end

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] step_count_q, step_count_d;
    logic [STEP_W-1:0] target_q, target_d;
    logic              dir_q, dir_d;
    logic              half_q, half_d;
    logic              done_q, done_d;
    logic [3:0]        coil_q, coil_d;
    logic [DIV_W-1:0]  period;
    logic [STEP_W-1:0] step_next;
    logic              step_now;

    function automatic logic [3:0] phase_pattern(input logic [2:0] i);
        logic [3:0] p;
        case (i)
            3'd0:    p = 4'b1000;
            3'd1:    p = 4'b1100;
            3'd2:    p = 4'b0100;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0010;
            3'd5:    p = 4'b0011;
            3'd6:    p = 4'b0001;
            default: p = 4'b1001;
        endcase
        return p;
    endfunction

    // Full-step lands on the odd (two-coil) entries: stride 2 from odd, 1 from even.
    function automatic logic [2:0] next_idx(input logic [2:0] i, input logic fwd, input logic half);
        logic [2:0] stride;
        stride = (half || !i[0]) ? 3'd1 : 3'd2;
        return fwd ? i + stride : i - stride;
    endfunction

    assign step_next = step_count_q + STEP_ONE;
    assign step_now  = (state_q == S_RUN) && !stop && (cnt_q == period - CNT_ONE);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        step_count_d = step_count_q;
        target_d     = target_q;
        dir_d        = dir_q;
        half_d       = half_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && steps_target != '0) begin
                    state_d      = S_RUN;
                    target_d     = steps_target;
                    dir_d        = dir;
                    half_d       = half_step;
                    step_count_d = '0;
                    cnt_d        = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (step_now) begin
                    cnt_d        = '0;
                    idx_d        = next_idx(idx_q, dir_q, half_q);
                    step_count_d = step_next;
                    if (step_next == target_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
        // The completing step's pattern is shown for one cycle before the idle blanking applies.
        coil_d = (state_q == S_RUN || state_d == S_RUN || HOLD_TORQUE != 0)
                 ? phase_pattern(idx_d) : 4'b0000;
    end

`ifdef STEPPER_RAMP_EN
    localparam logic [DIV_W:0] START_W = (DIV_W+1)'(START_DIV);
    localparam logic [DIV_W:0] MIN_W   = (DIV_W+1)'(MIN_DIV);
    localparam logic [DIV_W:0] ACC_W   = (DIV_W+1)'(ACCEL_DEC);

    logic [DIV_W-1:0]  period_q, period_d;
    logic [STEP_W-1:0] ramp_steps_q, ramp_steps_d;
    logic [DIV_W:0]    period_up;
    logic [STEP_W-1:0] remaining;

    assign period = period_q;

    always_comb begin
        period_d     = period_q;
        ramp_steps_d = ramp_steps_q;
        remaining    = target_q - step_next;
        period_up    = {1'b0, period_q} + ACC_W;
        if (state_q == S_IDLE && state_d == S_RUN) begin
            period_d     = START_W[DIV_W-1:0];
            ramp_steps_d = '0;
        end else if (step_now) begin
            // Decelerate once the remaining distance fits inside the accel distance used.
            if (remaining <= ramp_steps_q) begin
                period_d = (period_up > START_W) ? START_W[DIV_W-1:0] : period_up[DIV_W-1:0];
            end else if ({1'b0, period_q} > MIN_W) begin
                period_d     = ({1'b0, period_q} > MIN_W + ACC_W)
                               ? period_q - ACC_W[DIV_W-1:0] : MIN_W[DIV_W-1:0];
                ramp_steps_d = ramp_steps_q + STEP_ONE;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            period_q     <= START_W[DIV_W-1:0];
            ramp_steps_q <= '0;
        end else begin
            period_q     <= period_d;
            ramp_steps_q <= ramp_steps_d;
        end
    end
`else
    assign period = MIN_P;
`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            step_count_q <= '0;
            target_q     <= '0;
            dir_q        <= 1'b0;
            half_q       <= 1'b0;
            done_q       <= 1'b0;
            coil_q       <= 4'b0000;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            step_count_q <= step_count_d;
            target_q     <= target_d;
            dir_q        <= dir_d;
            half_q       <= half_d;
            done_q       <= done_d;
            coil_q       <= coil_d;
        end
    end

    assign coil       = coil_q;
    assign busy       = (state_q == S_RUN);
    assign done       = done_q;
    assign step_count = step_count_q;

endmodule
